wb_rr_arbiter: RTL and testbench
================================

Name: wb_rr_arbiter

Overview:
Two-master Wishbone classic (B3) arbiter that shares a single slave bus.
- Master 0 is the picorv32 Wishbone port; master 1 is a debug/DMA requester.
- Sits between the masters and the SoC interconnect/decoder.
- Grants whole cycles (CYC-framed) round-robin.
- Includes a bus watchdog that terminates stalled transfers with ERR, so a missing slave cannot hang the SoC.

Parameters:
AW, 32, address width
DW, 32, data width (SEL width = DW/8)
TIMEOUT, 255, cycles STB may wait for ACK/ERR before forced ERR; 0 disables watchdog

Ports:
clock  in  1  system clock, all logic on rising edge
reset  in  1  synchronous active-high reset
m_adr_i  in  2*AW  master addresses, master n at [n*AW +: AW]
m_dat_i  in  2*DW  master write data, packed as above
m_sel_i  in  2*DW/8  master byte selects, packed
m_we_i  in  2  master write enables, bit n = master n
m_cyc_i  in  2  master cycle requests
m_stb_i  in  2  master strobes
m_dat_o  out  DW  read data, broadcast to both masters (= s_dat_i)
m_ack_o  out  2  per-master ack
m_err_o  out  2  per-master error
s_adr_o  out  AW  slave address
s_dat_o  out  DW  slave write data
s_sel_o  out  DW/8  slave byte selects
s_we_o  out  1  slave write enable
s_cyc_o  out  1  slave cycle
s_stb_o  out  1  slave strobe
s_dat_i  in  DW  slave read data
s_ack_i  in  1  slave ack
s_err_i  in  1  slave error
grant_o  out  1  index of currently/last granted master (debug)

Behaviour:
- Reset (sync, highest priority, valid mid-transfer): state=IDLE, grant_o=1 (so master 0 wins the first tie), watchdog=0. s_cyc_o, s_stb_o, m_ack_o and m_err_o read 0 on the first cycle after reset.
- State IDLE, entry:
  - If any m_cyc_i is set, register the grant. With one requester, grant it. With both, grant the master != grant_o.
  - Move to BUSY next edge; 1-cycle arbitration latency from CYC to s_cyc_o.
- State IDLE, outputs: s_cyc_o=s_stb_o=0; all acks/errs 0.
- State BUSY, bus muxing: all s_* outputs combinationally follow master grant_o (adr/dat/sel/we/cyc/stb).
  - m_ack_o[g]=s_ack_i and m_err_o[g]=s_err_i|wd_err.
  - The non-granted master sees ack=err=0 and is held off regardless of its STB.
- State BUSY, release: when m_cyc_i[g] drops, s_cyc_o drops the same cycle, and state returns to IDLE at the edge.
  - A waiting requester is granted in IDLE the following cycle.
  - Minimum 1 idle cycle between grants.
  - The grant is never switched while granted CYC is high. Multi-beat (locked) cycles are preserved.
- Watchdog:
  - Counts edges where s_stb_o=1 and s_ack_i=0 and s_err_i=0. Clears on ACK/ERR, in IDLE, or when STB low.
  - When count==TIMEOUT-1 and no ACK/ERR this cycle, wd_err pulses for 1 cycle, but only if TIMEOUT!=0. This gives m_err_o[g]=1 exactly TIMEOUT cycles after STB rose, and the counter clears.
  - The slave still sees STB; the master is expected to end the cycle on ERR.
  - A slave ACK in the same cycle as a would-be timeout wins: no ERR.
  - s_ack_i and s_err_i together pass both through (slave fault; not masked).
- Simultaneous first request from both masters after reset: master 0 first, then master 1, then alternate while both keep requesting.
- Counter width: clog2(TIMEOUT+1); no wrap, saturating logic unnecessary since it clears at TIMEOUT.

Test Plan:
- Single master: reset, m_cyc_i=01, stb, slave acks 2 cycles after s_stb_o -> s_cyc_o rises 1 cycle after request, m_ack_o=01 for 1 cycle, m_dat_o=s_dat_i=0xDEADBEEF, grant_o=0.
- Contention: both CYC rise together, each performs 3 back-to-back single transfers -> grants 0,1,0,1,0,1 with one idle cycle between; m_ack_o[1] never high while grant_o=0.
- Locked burst: master 1 holds CYC across 4 STB/ACK beats while master 0 requests -> master 0 granted only after master 1 drops CYC.
- Watchdog: TIMEOUT=16, slave never acks -> m_err_o[g]=1 exactly 16 cycles after s_stb_o rise, single pulse. With ACK at cycle 16 -> ACK only, no ERR. TIMEOUT=0 -> no ERR after 1000 cycles.
- Reset mid-transfer: assert reset while BUSY with STB pending -> next cycle s_cyc_o=s_stb_o=0, grant_o=1, no ack/err. After release with both requesting, master 0 is granted.

Source files
------------

// File: rtl/wb_rr_arbiter.sv
// -----------------------------------------------------------------------------
// wb_rr_arbiter
// Two-master Wishbone classic (B3) arbiter that shares one slave bus.
// Master 0 is the CPU port and master 1 is a debug/DMA requester. Whole
// CYC-framed cycles are granted round-robin, so a multi-beat (locked) cycle is
// never split. A bus watchdog ends a stalled strobe with ERR, so a missing
// slave cannot hang the SoC.
//
// Parameters
//   AW       address width
//   DW       data width (byte-select width is DW/8)
//   TIMEOUT  cycles a strobe may wait for ACK/ERR before a forced ERR;
//            0 disables the watchdog
//
// Ports
//   clock, reset        system clock, synchronous active-high reset
//   m_adr_i/m_dat_i/    packed master request fields, master n in slice n
//   m_sel_i/m_we_i/
//   m_cyc_i/m_stb_i
//   m_dat_o             slave read data broadcast to both masters
//   m_ack_o/m_err_o     per-master termination, only the granted master
//   s_adr_o .. s_stb_o  request fields of the granted master towards slave
//   s_dat_i/s_ack_i/    slave response
//   s_err_i
//   grant_o             index of the current / last granted master
// -----------------------------------------------------------------------------
module wb_rr_arbiter #(
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int TIMEOUT = 255
) (
   input  logic                clock,
   input  logic                reset,
   input  logic [2*AW-1:0]     m_adr_i,
   input  logic [2*DW-1:0]     m_dat_i,
   input  logic [2*(DW/8)-1:0] m_sel_i,
   input  logic [1:0]          m_we_i,
   input  logic [1:0]          m_cyc_i,
   input  logic [1:0]          m_stb_i,
   output logic [DW-1:0]       m_dat_o,
   output logic [1:0]          m_ack_o,
   output logic [1:0]          m_err_o,
   output logic [AW-1:0]       s_adr_o,
   output logic [DW-1:0]       s_dat_o,
   output logic [DW/8-1:0]     s_sel_o,
   output logic                s_we_o,
   output logic                s_cyc_o,
   output logic                s_stb_o,
   input  logic [DW-1:0]       s_dat_i,
   input  logic                s_ack_i,
   input  logic                s_err_i,
   output logic                grant_o
);

   localparam int SW = DW / 8;

   // Counter only has to reach TIMEOUT-1; keep at least one bit when disabled.
   localparam int          CW        = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam int unsigned WD_LAST_I = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
   localparam logic [CW-1:0] WD_LAST = WD_LAST_I[CW-1:0];
   localparam logic        WD_EN     = (TIMEOUT != 0) ? 1'b1 : 1'b0;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_BUSY = 1'b1;

   logic [0:0]    state_r;
   logic          grant_r;
   logic [CW-1:0] wd_cnt_r;

   logic          busy_s;
   logic          g_cyc_s;
   logic          g_stb_s;
   logic          g_we_s;
   logic          next_grant_s;
   logic          stall_s;
   logic          wd_err_s;

   assign busy_s  = (state_r == ST_BUSY);
   assign g_cyc_s = m_cyc_i[grant_r];
   assign g_stb_s = m_stb_i[grant_r];
   assign g_we_s  = m_we_i[grant_r];

   assign grant_o = grant_r;
   assign m_dat_o = s_dat_i;

   // Request fields of the granted master; handshake lines only while BUSY.
   always_comb begin
      if (grant_r) begin
         s_adr_o = m_adr_i[AW +: AW];
         s_dat_o = m_dat_i[DW +: DW];
         s_sel_o = m_sel_i[SW +: SW];
      end else begin
         s_adr_o = m_adr_i[0 +: AW];
         s_dat_o = m_dat_i[0 +: DW];
         s_sel_o = m_sel_i[0 +: SW];
      end
      s_cyc_o = busy_s & g_cyc_s;
      s_stb_o = busy_s & g_stb_s;
      s_we_o  = busy_s & g_we_s;
   end

   // A strobe that is still waiting; reaching the limit raises a one-cycle ERR.
   // A slave ACK or ERR in the same cycle takes precedence over the timeout.
   always_comb begin
      stall_s  = s_stb_o & ~s_ack_i & ~s_err_i;
      wd_err_s = WD_EN & stall_s & (wd_cnt_r == WD_LAST);
   end

   // Route slave termination to the granted master only; the other sees zeros.
   always_comb begin
      m_ack_o = 2'b00;
      m_err_o = 2'b00;
      if (busy_s) begin
         m_ack_o[grant_r] = s_ack_i;
         m_err_o[grant_r] = s_err_i | wd_err_s;
      end else begin
         m_ack_o = 2'b00;
         m_err_o = 2'b00;
      end
   end

   // Round-robin choice: a lone requester wins, a tie goes to the other master.
   always_comb begin
      case (m_cyc_i)
         2'b01:   next_grant_s = 1'b0;
         2'b10:   next_grant_s = 1'b1;
         2'b11:   next_grant_s = ~grant_r;
         default: next_grant_s = grant_r;
      endcase
   end

   // Arbitration FSM: grant latched in IDLE, held until the owner drops CYC.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_r <= ST_IDLE;
         grant_r <= 1'b1;          // master 0 wins the first tie
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (|m_cyc_i) begin
                  grant_r <= next_grant_s;
                  state_r <= ST_BUSY;
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_BUSY: begin
               if (!g_cyc_s) begin
                  state_r <= ST_IDLE;
               end else begin
                  state_r <= ST_BUSY;
               end
            end
            default: begin
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

   // Watchdog counter: counts waiting strobe cycles, clears on any termination.
   always_ff @(posedge clock) begin
      if (reset) begin
         wd_cnt_r <= '0;
      end else if (!WD_EN || !stall_s || wd_err_s) begin
         wd_cnt_r <= '0;
      end else begin
         wd_cnt_r <= wd_cnt_r + CW'(1);
      end
   end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_wb_rr_arbiter
// Self-checking bench for wb_rr_arbiter: a vector table for the basic single
// master / hand-over flow, directed sequences for contention, locked bursts,
// the watchdog and reset mid-transfer, then random traffic checked against a
// cycle-level reference model. A second instance with TIMEOUT=0 shares the
// inputs and is only examined in the disabled-watchdog test.
// -----------------------------------------------------------------------------
module tb_wb_rr_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int SW = DW / 8;
   localparam int TO = 16;

   logic              clock = 1'b0;
   logic              reset;
   logic [2*AW-1:0]   m_adr_i;
   logic [2*DW-1:0]   m_dat_i;
   logic [2*SW-1:0]   m_sel_i;
   logic [1:0]        m_we_i, m_cyc_i, m_stb_i;
   logic [DW-1:0]     s_dat_i;
   logic              s_ack_i, s_err_i;

   logic [DW-1:0]     m_dat_o;
   logic [1:0]        m_ack_o, m_err_o;
   logic [AW-1:0]     s_adr_o;
   logic [DW-1:0]     s_dat_o;
   logic [SW-1:0]     s_sel_o;
   logic              s_we_o, s_cyc_o, s_stb_o, grant_o;

   logic [DW-1:0]     z_m_dat_o;
   logic [1:0]        z_m_ack_o, z_m_err_o;
   logic [AW-1:0]     z_s_adr_o;
   logic [DW-1:0]     z_s_dat_o;
   logic [SW-1:0]     z_s_sel_o;
   logic              z_s_we_o, z_s_cyc_o, z_s_stb_o, z_grant_o;

   int errors = 0;
   int checks = 0;

   wb_rr_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
      .clock(clock), .reset(reset),
      .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_sel_i(m_sel_i), .m_we_i(m_we_i),
      .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i),
      .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o),
      .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
      .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o),
      .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i),
      .grant_o(grant_o)
   );

   wb_rr_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(0)) dut_nowd (
      .clock(clock), .reset(reset),
      .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_sel_i(m_sel_i), .m_we_i(m_we_i),
      .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i),
      .m_dat_o(z_m_dat_o), .m_ack_o(z_m_ack_o), .m_err_o(z_m_err_o),
      .s_adr_o(z_s_adr_o), .s_dat_o(z_s_dat_o), .s_sel_o(z_s_sel_o), .s_we_o(z_s_we_o),
      .s_cyc_o(z_s_cyc_o), .s_stb_o(z_s_stb_o),
      .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i),
      .grant_o(z_grant_o)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [1:0] cyc;
      logic [1:0] stb;
      logic       ack;
      logic       err;
      logic       e_cyc;
      logic       e_stb;
      logic [1:0] e_ack;
      logic [1:0] e_err;
      logic       e_grant;
   } vec_t;

   vec_t vt[15];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic idle_inputs();
      m_adr_i = '0; m_dat_i = '0; m_sel_i = '0; m_we_i = 2'b00;
      m_cyc_i = 2'b00; m_stb_i = 2'b00;
      s_dat_i = '0; s_ack_i = 1'b0; s_err_i = 1'b0;
   endtask

   task automatic do_reset();
      idle_inputs();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   // One watchdog run on master 0: ack_at = cycle (1 = STB rise) of a slave ACK, 0 = never.
   task automatic wd_run(input int ack_at, output int first_err, output int n_err, output int ack_cyc);
      logic drop;
      first_err = -1; n_err = 0; ack_cyc = -1; drop = 1'b0;
      do_reset();
      m_cyc_i = 2'b01; m_stb_i = 2'b01;
      tick();
      for (int k = 1; k <= 40; k++) begin
         s_ack_i = (k == ack_at);
         #2;
         if (k == 1) chk("wd_stb_rise", s_stb_o, 1'b1);
         if (m_err_o[0]) begin
            n_err++;
            if (first_err < 0) first_err = k;
         end
         if (m_ack_o[0] && ack_cyc < 0) ack_cyc = k;
         if (m_err_o != 2'b00 || m_ack_o != 2'b00) drop = 1'b1;
         tick();
         if (drop) begin
            m_cyc_i = 2'b00; m_stb_i = 2'b00;
         end
      end
      s_ack_i = 1'b0;
   endtask

   // Random-phase state and reference model state.
   bit   mb;        // model: a master owns the bus
   int   mg;        // model: current / last grant
   int   mw;        // model: strobe cycles already waited
   logic [1:0] rc;
   int   gl[$];
   int   fe, ne, ac;

   initial begin
      reset = 1'b1;
      idle_inputs();

      // ---------------- table: single master, hand-over, locked hold ----------
      vt[0]  = '{2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1};
      vt[1]  = '{2'b01, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1};
      vt[2]  = '{2'b01, 2'b01, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 2'b00, 1'b0};
      vt[3]  = '{2'b01, 2'b01, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 2'b00, 1'b0};
      vt[4]  = '{2'b01, 2'b01, 1'b1, 1'b0, 1'b1, 1'b1, 2'b01, 2'b00, 1'b0};
      vt[5]  = '{2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0};
      vt[6]  = '{2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0};
      vt[7]  = '{2'b10, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0};
      vt[8]  = '{2'b10, 2'b10, 1'b1, 1'b0, 1'b1, 1'b1, 2'b10, 2'b00, 1'b1};
      vt[9]  = '{2'b11, 2'b11, 1'b1, 1'b0, 1'b1, 1'b1, 2'b10, 2'b00, 1'b1};
      vt[10] = '{2'b11, 2'b11, 1'b0, 1'b1, 1'b1, 1'b1, 2'b00, 2'b10, 1'b1};
      vt[11] = '{2'b01, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1};
      vt[12] = '{2'b01, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1};
      vt[13] = '{2'b01, 2'b01, 1'b1, 1'b0, 1'b1, 1'b1, 2'b01, 2'b00, 1'b0};
      vt[14] = '{2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0};

      do_reset();
      m_adr_i = {32'h1111_0004, 32'h0000_0A00};
      s_dat_i = 32'hDEAD_BEEF;
      for (int i = 0; i < 15; i++) begin
         m_cyc_i = vt[i].cyc; m_stb_i = vt[i].stb;
         s_ack_i = vt[i].ack; s_err_i = vt[i].err;
         #2;
         chk($sformatf("vec%0d_s_cyc", i), s_cyc_o, vt[i].e_cyc);
         chk($sformatf("vec%0d_s_stb", i), s_stb_o, vt[i].e_stb);
         chk($sformatf("vec%0d_m_ack", i), m_ack_o, vt[i].e_ack);
         chk($sformatf("vec%0d_m_err", i), m_err_o, vt[i].e_err);
         chk($sformatf("vec%0d_grant", i), grant_o, vt[i].e_grant);
         chk($sformatf("vec%0d_m_dat", i), m_dat_o, 32'hDEAD_BEEF);
         if (vt[i].e_cyc)
            chk($sformatf("vec%0d_s_adr", i), s_adr_o,
                vt[i].e_grant ? 32'h1111_0004 : 32'h0000_0A00);
         tick();
      end

      // ---------------- contention: 3 single transfers per master -------------
      begin
         logic c0, c1, pend, prev, bad1;
         int   d0, d1;
         do_reset();
         c0 = 1'b1; c1 = 1'b1; pend = 1'b0; prev = 1'b0; bad1 = 1'b0;
         d0 = 0; d1 = 0;
         for (int k = 0; k < 120 && (d0 < 3 || d1 < 3); k++) begin
            m_cyc_i = {c1, c0}; m_stb_i = {c1, c0}; s_ack_i = pend;
            #2;
            if (s_cyc_o && !prev) gl.push_back(int'(grant_o));
            if (m_ack_o[1] && grant_o == 1'b0) bad1 = 1'b1;
            prev = s_cyc_o;
            pend = s_stb_o && !s_ack_i;
            if (m_ack_o[0]) begin d0++; c0 = 1'b0; end
            else if (!c0 && d0 < 3) c0 = 1'b1;
            if (m_ack_o[1]) begin d1++; c1 = 1'b0; end
            else if (!c1 && d1 < 3) c1 = 1'b1;
            tick();
         end
         s_ack_i = 1'b0;
         chk("cont_done", d0 + d1, 6);
         chk("cont_ngrants", gl.size(), 6);
         for (int i = 0; i < gl.size(); i++)
            chk($sformatf("cont_grant%0d", i), gl[i], i % 2);
         chk("cont_ack1_under_g0", bad1, 1'b0);
      end

      // ---------------- locked burst: master 1 holds CYC for 4 beats ----------
      do_reset();
      m_cyc_i = 2'b10; m_stb_i = 2'b10;
      tick();
      m_cyc_i = 2'b11; m_stb_i = 2'b11;
      for (int b = 0; b < 8; b++) begin
         s_ack_i = (b % 2 == 1);
         #2;
         chk($sformatf("lock_ack_b%0d", b), m_ack_o, {s_ack_i, 1'b0});
         chk($sformatf("lock_grant_b%0d", b), grant_o, 1'b1);
         tick();
      end
      s_ack_i = 1'b0;
      m_cyc_i = 2'b01; m_stb_i = 2'b01;
      #2;
      chk("lock_release_cyc", s_cyc_o, 1'b0);
      tick(); #2;
      chk("lock_idle_cyc", s_cyc_o, 1'b0);
      chk("lock_idle_grant", grant_o, 1'b1);
      tick(); #2;
      chk("lock_next_cyc", s_cyc_o, 1'b1);
      chk("lock_next_grant", grant_o, 1'b0);

      // ---------------- watchdog ----------------------------------------------
      wd_run(0, fe, ne, ac);
      chk("wd_first_err_cycle", fe, TO);
      chk("wd_err_pulses", ne, 1);
      wd_run(TO, fe, ne, ac);
      chk("wd_ack_wins_cycle", ac, TO);
      chk("wd_ack_wins_no_err", ne, 0);

      begin
         int zerr;
         zerr = 0;
         do_reset();
         m_cyc_i = 2'b01; m_stb_i = 2'b01;
         for (int k = 0; k < 1000; k++) begin
            #2;
            if (z_m_err_o != 2'b00) zerr++;
            tick();
         end
         chk("nowd_err_count", zerr, 0);
         chk("nowd_still_stalled", z_s_stb_o, 1'b1);
      end

      // ---------------- reset mid-transfer ------------------------------------
      do_reset();
      m_cyc_i = 2'b01; m_stb_i = 2'b01;
      tick(); tick(); tick();
      #2;
      chk("rst_mid_busy_before", s_stb_o, 1'b1);
      reset = 1'b1;
      m_cyc_i = 2'b11; m_stb_i = 2'b11;
      tick();
      reset = 1'b0;
      #2;
      chk("rst_mid_s_cyc", s_cyc_o, 1'b0);
      chk("rst_mid_s_stb", s_stb_o, 1'b0);
      chk("rst_mid_grant", grant_o, 1'b1);
      chk("rst_mid_ack", m_ack_o, 2'b00);
      chk("rst_mid_err", m_err_o, 2'b00);
      tick(); #2;
      chk("rst_mid_regrant_cyc", s_cyc_o, 1'b1);
      chk("rst_mid_regrant_m0", grant_o, 1'b0);

      // ---------------- random traffic vs reference model ---------------------
      do_reset();
      mb = 1'b0; mg = 1; mw = 0; rc = 2'b00;
      for (int k = 0; k < 2400; k++) begin
         logic [1:0] e_ack, e_err;
         logic gc, gs, wd;
         if ($urandom_range(0, 3) == 0) rc[0] = ~rc[0];
         if ($urandom_range(0, 3) == 0) rc[1] = ~rc[1];
         m_cyc_i = rc;
         m_stb_i = rc & {($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0)};
         m_we_i  = 2'($urandom);
         m_adr_i = {$urandom, $urandom};
         m_dat_i = {$urandom, $urandom};
         m_sel_i = 8'($urandom);
         s_dat_i = $urandom;
         s_ack_i = ((k / 400) % 2 == 1) ? ($urandom_range(0, 39) == 0) : ($urandom_range(0, 2) == 0);
         s_err_i = ($urandom_range(0, 31) == 0);
         reset   = ($urandom_range(0, 299) == 0);
         #2;
         gc = m_cyc_i[mg];
         gs = m_stb_i[mg];
         wd = mb && gs && !s_ack_i && !s_err_i && (mw == TO - 1);
         e_ack = 2'b00; e_err = 2'b00;
         if (mb) begin
            e_ack[mg] = s_ack_i;
            e_err[mg] = s_err_i | wd;
         end
         chk("rnd_s_cyc", s_cyc_o, mb && gc);
         chk("rnd_s_stb", s_stb_o, mb && gs);
         chk("rnd_m_ack", m_ack_o, e_ack);
         chk("rnd_m_err", m_err_o, e_err);
         chk("rnd_grant", grant_o, mg);
         chk("rnd_m_dat", m_dat_o, s_dat_i);
         if (mb) begin
            chk("rnd_s_adr", s_adr_o, m_adr_i[mg*AW +: AW]);
            chk("rnd_s_dat", s_dat_o, m_dat_i[mg*DW +: DW]);
            chk("rnd_s_sel", s_sel_o, m_sel_i[mg*SW +: SW]);
            chk("rnd_s_we", s_we_o, m_we_i[mg]);
         end
         if (reset) begin
            mb = 1'b0; mg = 1; mw = 0;
         end else if (!mb) begin
            if (m_cyc_i == 2'b11) begin mg = 1 - mg; mb = 1'b1; end
            else if (m_cyc_i == 2'b01) begin mg = 0; mb = 1'b1; end
            else if (m_cyc_i == 2'b10) begin mg = 1; mb = 1'b1; end
            mw = 0;
         end else begin
            mw = (gs && !s_ack_i && !s_err_i && !wd) ? mw + 1 : 0;
            if (!gc) mb = 1'b0;
         end
         tick();
      end
      reset = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
